nx_tmon_snapshot_sched: RTL
===========================

// Module: nx_tmon_snapshot_sched
// PURPOSE
// Producer-side scheduler for the double-banked table monitor. Round-robin arbitrates snapshot
// requests from N_REQ clients and gates each on monitor write credit. It copies N_ENTRIES/2
// words from a 1-cycle-latency source read port into the next bank, then pulses tmon_credit_used.
// Sits between the capture clients and the table monitor's table_data/credit interface.
// PARAMETERS
// N_REQ        4   number of snapshot requesters (>=1)
// N_ENTRIES    16  monitor table depth, even; one bank = N_ENTRIES/2 words
// N_DATA_BITS  32  table word width
// N_TIMER_BITS 6   credit-wait timeout counter width
// PORTS
// clk                    in   1                   clock
// rst_n                  in   1                   async active-low reset
// req                    in   N_REQ               level snapshot request per client
// gnt                    out  N_REQ               one-hot, 1-cycle pulse at capture start
// done                   out  N_REQ               one-hot, 1-cycle pulse with tmon_credit_used
// tmon_credit_available  in   1                   monitor has a free bank
// tmon_credit_used       out  1                   1-cycle pulse, bank committed
// src_rd                 out  1                   source read strobe
// src_addr               out  LOG_VEC(N_ENTRIES/2) source word index
// src_rdat               in   N_DATA_BITS         valid the cycle after src_rd
// cap_we                 out  1                   table write strobe
// cap_addr               out  LOG_VEC(N_ENTRIES)  table address incl. bank base
// cap_dat                out  N_DATA_BITS         table write data
// timeout_err            out  1                   sticky: credit wait exceeded 2^N_TIMER_BITS-1 cycles
// snap_cnt               out  16                  committed snapshots, wraps
// BEHAVIOUR
// - Reset: every output 0; FSM IDLE; bank=lo; rr pointer=0; timer=0.
// - FSM IDLE: if |req, pick first set req at or after rr pointer -> WAIT_CR, latch winner.
// - WAIT_CR: timer increments each cycle. On tmon_credit_available: gnt[winner]=1, timer cleared,
//   -> CAPTURE. At timer all-ones: set timeout_err, keep waiting, no wrap.
// - CAPTURE: src_rd=1, src_addr 0..N_ENTRIES/2-1 on consecutive cycles.
//   The cycle after each rd: cap_we=1, cap_dat=src_rdat, cap_addr=src_addr_d + (bank ? N_ENTRIES/2 : 0).
//   The cycle after the last write: -> COMMIT.
// - COMMIT (1 cycle): tmon_credit_used=1, done[winner]=1, bank toggles, snap_cnt+1,
//   rr pointer=winner+1 mod N_REQ -> IDLE.
// - Latency with credit already available: req-to-gnt = 2 cycles; gnt-to-commit = N_ENTRIES/2+2 cycles.
// - req deasserted after latching is ignored; the snapshot completes. A requester is served at most
//   once per pass; a requester still asserting req is re-arbitrated fairly after commit.
// - Bank toggles only at COMMIT, so it always matches the monitor's write bank.
// - Credit drop during CAPTURE is legal and ignored; credit was checked at grant.
// - timeout_err is cleared only by reset. snap_cnt wraps 0xFFFF->0.
// - Reset mid-CAPTURE: all state clears; a partial bank is never committed.
// STRUCTURE
// - Package nx_tmon_sched_pkg: FSM enum tmon_sched_state_e {IDLE,WAIT_CR,CAPTURE,COMMIT}.
// - Sub-module nx_rr_arb #(N): combinational round-robin pick from (req, ptr).
//   Outputs: winner index, any.
// - Capture pipeline register: one stage (src_addr_d, rd_d); no FIFO.
// TESTING
// - N_ENTRIES=16, credit=1, req=4'b0001 -> gnt[0] @t+2; cap_addr 0..7 @t+4..t+11; credit_used/done[0] @t+12.
// - Second request after the first -> cap_addr 8..15 (hi bank); third -> back to 0..7; snap_cnt=3.
// - req=4'b1111 held, credit=1 -> grants in order 0,1,2,3,0.
// - credit=0 for 70 cycles (N_TIMER_BITS=6) -> timeout_err=1 at cycle 63; credit=1 -> capture runs normally.
// - rst_n low mid-CAPTURE (word 3) -> cap_we/tmon_credit_used stay 0; next snapshot uses bank lo, addr 0.
// - Credit deasserted mid-capture -> all 8 writes plus commit still occur; src_rdat pattern 'hA5+i matches cap_dat.

Source files
------------

// File: rtl/nx_tmon_snapshot_sched_pkg.sv
// Shared types and helpers for the table-monitor snapshot scheduler.
package nx_tmon_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CR,
    CAPTURE,
    COMMIT
  } tmon_sched_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int log_vec(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_tmon_snapshot_sched_if.sv
// Client request, source read, table write and status signals of the snapshot scheduler.
interface nx_tmon_snapshot_sched_if import nx_tmon_sched_pkg::*; #(
  parameter int N_REQ       = 4,
  parameter int N_ENTRIES   = 16,
  parameter int N_DATA_BITS = 32
);

  localparam int AW = log_vec(N_ENTRIES / 2);
  localparam int TW = log_vec(N_ENTRIES);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   tmon_credit_available;
  logic                   tmon_credit_used;
  logic                   src_rd;
  logic [AW-1:0]          src_addr;
  logic [N_DATA_BITS-1:0] src_rdat;
  logic                   cap_we;
  logic [TW-1:0]          cap_addr;
  logic [N_DATA_BITS-1:0] cap_dat;
  logic                   timeout_err;
  logic [15:0]            snap_cnt;

  modport master (
    input  req, tmon_credit_available, src_rdat,
    output gnt, done, tmon_credit_used, src_rd, src_addr,
           cap_we, cap_addr, cap_dat, timeout_err, snap_cnt
  );

  modport slave (
    output req, tmon_credit_available, src_rdat,
    input  gnt, done, tmon_credit_used, src_rd, src_addr,
           cap_we, cap_addr, cap_dat, timeout_err, snap_cnt
  );

endinterface

// File: rtl/nx_tmon_snapshot_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer.
module nx_rr_arb import nx_tmon_sched_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = log_vec(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest request to ptr_i wins.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_i) + i) % N);
      if (req_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_tmon_snapshot_sched.sv
// Producer-side scheduler: arbitrates snapshot clients, waits for monitor credit,
// copies one bank of words from the source port into the table, then commits it.
module nx_tmon_snapshot_sched import nx_tmon_sched_pkg::*; #(
  parameter int N_REQ        = 4,
  parameter int N_ENTRIES    = 16,
  parameter int N_DATA_BITS  = 32,
  parameter int N_TIMER_BITS = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  nx_tmon_snapshot_sched_if.master bus
);

  localparam int HALF = N_ENTRIES / 2;
  localparam int AW   = log_vec(HALF);
  localparam int TW   = log_vec(N_ENTRIES);
  localparam int IW   = log_vec(N_REQ);
  localparam int CW   = $clog2(HALF + 1);

  tmon_sched_state_e state_q, state_d;

  logic [IW-1:0]           winner_q, ptr_q, arb_winner, ptr_next;
  logic                    arb_any;
  logic [N_REQ-1:0]        winner_oh, gnt, done;
  logic                    credit_used;
  logic [N_TIMER_BITS-1:0] timer_q, timer_d;
  logic                    timeout_err_q;
  logic [CW-1:0]           rd_idx_q;
  logic                    src_rd;
  logic [AW-1:0]           src_addr;
  logic                    rd_d_q;
  logic [AW-1:0]           src_addr_d_q;
  logic                    cap_we_q, cap_last_q;
  logic [TW-1:0]           cap_addr_q, cap_addr_d;
  logic [N_DATA_BITS-1:0]  cap_dat_q;
  logic                    bank_q;
  logic [15:0]             snap_cnt_q;

  nx_rr_arb #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  assign winner_oh  = N_REQ'(1) << winner_q;
  assign ptr_next   = (winner_q == IW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
  assign cap_addr_d = TW'(src_addr_d_q) + (bank_q ? TW'(HALF) : TW'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = WAIT_CR;
      WAIT_CR: if (bus.tmon_credit_available) state_d = CAPTURE;
      CAPTURE: if (cap_we_q && cap_last_q) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads issue while the word index is below the bank size; writes trail by the pipeline.
  always_comb begin
    src_rd      = 1'b0;
    src_addr    = '0;
    gnt         = '0;
    done        = '0;
    credit_used = 1'b0;
    case (state_q)
      CAPTURE: begin
        src_rd   = (rd_idx_q < CW'(HALF));
        src_addr = src_rd ? rd_idx_q[AW-1:0] : '0;
        if (rd_idx_q == '0) gnt = winner_oh;
      end
      COMMIT: begin
        credit_used = 1'b1;
        done        = winner_oh;
      end
      default: ;
    endcase
  end

  // Saturating credit-wait timer; it only runs while waiting without credit.
  always_comb begin
    timer_d = '0;
    if (state_q == WAIT_CR && !bus.tmon_credit_available)
      timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q      <= '0;
      ptr_q         <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      rd_idx_q      <= '0;
      rd_d_q        <= 1'b0;
      src_addr_d_q  <= '0;
      cap_we_q      <= 1'b0;
      cap_last_q    <= 1'b0;
      cap_addr_q    <= '0;
      cap_dat_q     <= '0;
      bank_q        <= 1'b0;
      snap_cnt_q    <= '0;
    end else begin
      timer_q <= timer_d;
      if (&timer_d) timeout_err_q <= 1'b1;
      if (state_q == IDLE && arb_any) winner_q <= arb_winner;
      if (state_q == CAPTURE) rd_idx_q <= src_rd ? rd_idx_q + 1'b1 : rd_idx_q;
      else                    rd_idx_q <= '0;
      rd_d_q       <= src_rd;
      src_addr_d_q <= src_addr;
      cap_we_q     <= rd_d_q;
      cap_addr_q   <= rd_d_q ? cap_addr_d : '0;
      cap_dat_q    <= rd_d_q ? bus.src_rdat : '0;
      cap_last_q   <= rd_d_q && (src_addr_d_q == AW'(HALF - 1));
      // Bank flips only on commit so it tracks the monitor's write bank.
      if (state_q == COMMIT) begin
        bank_q     <= ~bank_q;
        snap_cnt_q <= snap_cnt_q + 1'b1;
        ptr_q      <= ptr_next;
      end
    end
  end

  assign bus.gnt              = gnt;
  assign bus.done             = done;
  assign bus.tmon_credit_used = credit_used;
  assign bus.src_rd           = src_rd;
  assign bus.src_addr         = src_addr;
  assign bus.cap_we           = cap_we_q;
  assign bus.cap_addr         = cap_addr_q;
  assign bus.cap_dat          = cap_dat_q;
  assign bus.timeout_err      = timeout_err_q;
  assign bus.snap_cnt         = snap_cnt_q;

endmodule
